// File: rtl/hyperram_rd_streamer.sv
// hyperram_rd_streamer: breaks a read request into HyperRAM bursts and streams the returned words through a FWFT buffer.
// Latency: a burst opens two or more cycles after the request is accepted; each word is visible on rd_data the cycle after its strobe.
// Backpressure: req_ready follows ctrl_ready in IDLE only; rd_ready stalls hold the next burst in CREDIT until the whole burst fits.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake carrying req_addr, req_num_words
//   rd_data/rd_valid/rd_ready        read-word stream to the consumer (first-word-fall-through)
//   busy, err                        request in progress; sticky watchdog timeout
//   ctrl_*                           HyperRAM controller burst interface (cs/mode/num_words/latency/addr out,
//                                    ready, rd_data_out, rd_data_valid in)
//
// Build option: define HYPERRAM_RD_TIMEOUT_EN to add a 16-bit watchdog on stalled bursts that drives err.
// Without it err is tied low and no watchdog exists.

// Generic first-word-fall-through FIFO. A write while full is only taken when a pop happens in the
// same cycle; the producer here never overruns because space is reserved before each burst.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             full;
  logic             push;
  logic             pop;

  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign rd_vld = (cnt_q != '0);
  assign pop    = rd_vld && rd_rdy;
  // A pop frees the head slot this cycle, so a push at full is still safe.
  assign push   = wr_vld && (!full || pop);
  // Head is forced to zero when empty so rd_data is clean after reset.
  assign rd_dat = rd_vld ? mem[rptr_q] : '0;
  assign level  = cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module hyperram_rd_streamer #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         BURST_MAX  = 8,
  parameter int         ADDR_STEP  = 2,
  parameter logic [2:0] LATENCY    = 3'd6,
  parameter logic [1:0] MODE_RD    = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_num_words,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        err,
  input  logic        ctrl_ready,
  output logic        ctrl_cs,
  output logic [1:0]  ctrl_mode,
  output logic [31:0] ctrl_num_words,
  output logic [2:0]  ctrl_latency,
  output logic [31:0] ctrl_addr_in,
  input  logic [31:0] ctrl_rd_data_out,
  input  logic        ctrl_rd_data_valid
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    ISSUE  = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [31:0]     addr_q;       // address of the next burst
  logic [31:0]     remaining_q;  // words not yet covered by a completed burst
  logic [31:0]     blen_q;       // length of the burst in flight
  logic [31:0]     beat_q;       // strobes received in the burst in flight
  logic [31:0]     blen_calc;
  logic [31:0]     free_slots;
  logic [LW-1:0]   fifo_level;
  logic            req_fire;
  logic            strobe;
  logic            last_beat;
  logic            credit_ok;
  logic            timeout_hit;
  logic            burst_end;

  // Held low during reset so no handshake can be seen while the block is cleared.
  assign req_ready  = rst_n && (state_q == IDLE) && ctrl_ready;
  assign req_fire   = req_valid && req_ready;
  // Only strobes that land inside an open burst are real data.
  assign strobe     = (state_q == ISSUE) && ctrl_rd_data_valid;
  assign last_beat  = strobe && ((beat_q + 32'd1) == blen_q);
  assign blen_calc  = (remaining_q < 32'(BURST_MAX)) ? remaining_q : 32'(BURST_MAX);
  // Occupancy is taken before any same-cycle pop, so the reservation is conservative
  // and the burst can never overrun the buffer whatever rd_ready does.
  assign free_slots = 32'(FIFO_DEPTH) - 32'(fifo_level);
  assign credit_ok  = (free_slots >= blen_calc) && ctrl_ready;
  assign burst_end  = last_beat || timeout_hit;

`ifdef HYPERRAM_RD_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        err_q;

  // Fires only on a quiet cycle so a late final strobe still completes the burst normally.
  assign timeout_hit = (state_q == ISSUE) && !ctrl_rd_data_valid && (wd_q == 16'hFFFF);
  assign err         = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q == ISSUE) && !ctrl_rd_data_valid) begin
        if (wd_q != 16'hFFFF) begin
          wd_q <= wd_q + 16'd1;
        end
      end else begin
        wd_q <= '0;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A zero-length request is acknowledged and otherwise ignored.
        if (req_fire && (req_num_words != 32'd0)) begin
          state_d = CREDIT;
        end
      end
      CREDIT: begin
        if (credit_ok) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (burst_end) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = (remaining_q != 32'd0) ? CREDIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request / burst bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      blen_q      <= '0;
      beat_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            addr_q      <= req_addr;
            remaining_q <= req_num_words;
          end
        end
        CREDIT: begin
          if (credit_ok) begin
            blen_q <= blen_calc;
            beat_q <= '0;
          end
        end
        ISSUE: begin
          if (strobe) begin
            beat_q <= beat_q + 32'd1;
          end
          if (last_beat) begin
            // Address arithmetic wraps at 32 bits by construction.
            addr_q      <= addr_q + (blen_q * 32'(ADDR_STEP));
            remaining_q <= remaining_q - blen_q;
          end else if (timeout_hit) begin
            // Abandon the rest of the request; GAP then falls back to IDLE.
            remaining_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: burst fields are only driven while the burst is open.
  always_comb begin
    ctrl_cs        = 1'b0;
    ctrl_mode      = 2'b00;
    ctrl_num_words = '0;
    ctrl_addr_in   = '0;
    busy           = (state_q != IDLE);
    if (state_q == ISSUE) begin
      ctrl_cs        = 1'b1;
      ctrl_mode      = MODE_RD;
      ctrl_num_words = blen_q;
      ctrl_addr_in   = addr_q;
    end
  end

  assign ctrl_latency = LATENCY;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (strobe),
    .wr_dat (ctrl_rd_data_out),
    .rd_rdy (rd_ready),
    .rd_vld (rd_valid),
    .rd_dat (rd_data),
    .level  (fifo_level)
  );
endmodule

// File: tb/tb_hyperram_rd_streamer.sv
module tb_hyperram_rd_streamer;
  localparam int BMAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_num_words;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        err;
  logic        ctrl_ready;
  logic        ctrl_cs;
  logic [1:0]  ctrl_mode;
  logic [31:0] ctrl_num_words;
  logic [2:0]  ctrl_latency;
  logic [31:0] ctrl_addr_in;
  logic [31:0] ctrl_rd_data_out;
  logic        ctrl_rd_data_valid;

  always #5 clk = ~clk;

  hyperram_rd_streamer #(
    .FIFO_DEPTH (16),
    .BURST_MAX  (BMAX),
    .ADDR_STEP  (2),
    .LATENCY    (3'd6),
    .MODE_RD    (2'b01)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_addr           (req_addr),
    .req_num_words      (req_num_words),
    .rd_data            (rd_data),
    .rd_valid           (rd_valid),
    .rd_ready           (rd_ready),
    .busy               (busy),
    .err                (err),
    .ctrl_ready         (ctrl_ready),
    .ctrl_cs            (ctrl_cs),
    .ctrl_mode          (ctrl_mode),
    .ctrl_num_words     (ctrl_num_words),
    .ctrl_latency       (ctrl_latency),
    .ctrl_addr_in       (ctrl_addr_in),
    .ctrl_rd_data_out   (ctrl_rd_data_out),
    .ctrl_rd_data_valid (ctrl_rd_data_valid)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    bit          last;
  } burst_t;

  burst_t      exp_burst[$];
  logic [31:0] exp_data[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_mode = 0;      // 0: always ready, 1: random, 2: held off
  int          strobe_pct = 100;
  int          beats_sent = 0;
  bit          prev_cs = 1'b0;
  bit          gap_pending = 1'b0;
  bit          gap_last = 1'b0;
  bit          cur_last = 1'b0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_len = '0;

  // Contents of the simulated HyperRAM: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: the words a request returns, and how it splits into bursts.
  task automatic model_request(input logic [31:0] addr, input logic [31:0] n);
    logic [31:0] a;
    logic [31:0] rem;
    logic [31:0] len;
    burst_t      b;
    for (int j = 0; j < int'(n); j++) begin
      exp_data.push_back(mem_word(addr + 32'(2 * j)));
    end
    a   = addr;
    rem = n;
    while (rem != 0) begin
      len    = (rem > 32'(BMAX)) ? 32'(BMAX) : rem;
      b.addr = a;
      b.len  = len;
      b.last = (rem == len);
      exp_burst.push_back(b);
      a   = a + len * 32'd2;
      rem = rem - len;
    end
  endtask

  task automatic send_req(input logic [31:0] a, input logic [31:0] n);
    bit done;
    done = 1'b0;
    model_request(a, n);
    @(posedge clk); #1;
    req_valid     = 1'b1;
    req_addr      = a;
    req_num_words = n;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) fail_now("req_handshake_timeout");
    else checks++;
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      @(negedge clk);
      if (!busy && exp_data.size() == 0 && exp_burst.size() == 0) ok = 1'b1;
    end
    if (!ok) fail_now("request_completion_timeout");
    else checks++;
  endtask

  task automatic run_req(input logic [31:0] a, input logic [31:0] n);
    send_req(a, n);
    wait_done(3000);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_ctrl_cs"}, 32'(ctrl_cs), 32'd0);
    chk({tag, "_ctrl_mode"}, 32'(ctrl_mode), 32'd0);
    chk({tag, "_ctrl_num_words"}, ctrl_num_words, 32'd0);
    chk({tag, "_ctrl_addr_in"}, ctrl_addr_in, 32'd0);
  endtask

  // HyperRAM interface model: returns the requested words with random pacing and
  // throws junk strobes whenever no burst is open.
  initial begin
    ctrl_rd_data_valid = 1'b0;
    ctrl_rd_data_out   = '0;
    ctrl_ready         = 1'b1;
    forever begin
      @(posedge clk); #1;
      ctrl_ready         = ($urandom_range(0, 9) != 0);
      ctrl_rd_data_valid = 1'b0;
      ctrl_rd_data_out   = '0;
      if (ctrl_cs) begin
        if (beats_sent < int'(ctrl_num_words) && $urandom_range(1, 100) <= strobe_pct) begin
          ctrl_rd_data_valid = 1'b1;
          ctrl_rd_data_out   = mem_word(ctrl_addr_in + 32'(2 * beats_sent));
          beats_sent++;
        end
      end else begin
        beats_sent = 0;
        if ($urandom_range(0, 7) == 0) begin
          ctrl_rd_data_valid = 1'b1;
          ctrl_rd_data_out   = 32'hDEAD_0000 | 32'($urandom_range(0, 65535));
        end
      end
    end
  end

  // Consumer model.
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rd_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cs     = 1'b0;
        gap_pending = 1'b0;
      end else begin
        chk("ctrl_latency", 32'(ctrl_latency), 32'd6);
        chk("err_low", 32'(err), 32'd0);
        if (gap_pending) begin
          // One cycle after GAP: IDLE if that was the final burst, otherwise CREDIT.
          chk(gap_last ? "busy_after_final_gap" : "busy_after_mid_gap", 32'(busy),
              gap_last ? 32'd0 : 32'd1);
          chk("cs_after_gap", 32'(ctrl_cs), 32'd0);
          gap_pending = 1'b0;
        end
        if (ctrl_cs && !prev_cs) begin
          if (exp_burst.size() == 0) begin
            fail_now("unexpected_burst");
          end else begin
            burst_t b;
            b        = exp_burst.pop_front();
            cur_addr = b.addr;
            cur_len  = b.len;
            cur_last = b.last;
          end
        end
        if (ctrl_cs) begin
          chk("burst_addr", ctrl_addr_in, cur_addr);
          chk("burst_len", ctrl_num_words, cur_len);
          chk("burst_mode", 32'(ctrl_mode), 32'd1);
          chk("busy_in_burst", 32'(busy), 32'd1);
        end else begin
          chk("idle_ctrl_fields", ctrl_num_words | ctrl_addr_in | 32'(ctrl_mode), 32'd0);
        end
        if (!ctrl_cs && prev_cs) begin
          chk("busy_in_gap", 32'(busy), 32'd1);
          gap_pending = 1'b1;
          gap_last    = cur_last;
        end
        if (rd_valid && rd_ready) begin
          if (exp_data.size() == 0) fail_now("unexpected_word");
          else chk("rd_data", rd_data, exp_data.pop_front());
        end
        prev_cs = ctrl_cs;
      end
    end
  end

  // Hard stop so the bench can never hang.
  initial begin
    #1000000;
    $display("FAIL global_timeout at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bit got3;
    logic [31:0] a;
    logic [31:0] n;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_num_words = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_req_ready", 32'(req_ready), 32'(ctrl_ready));
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Single short burst.
    rd_mode    = 0;
    strobe_pct = 100;
    run_req(32'h0000_0100, 32'd5);

    // Multi-burst split 8/8/4 with paced strobes.
    strobe_pct = 70;
    run_req(32'h0000_1000, 32'd20);

    // Consumer stalled: burst issue must hold off once the buffer is committed.
    rd_mode    = 2;
    strobe_pct = 100;
    send_req(32'h0000_2000, 32'd40);
    repeat (150) @(negedge clk);
    chk("stall_cs_low", 32'(ctrl_cs), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_rd_valid", 32'(rd_valid), 32'd1);
    chk("stall_words_left", 32'(exp_data.size()), 32'd40);
    rd_mode = 0;
    wait_done(3000);

    // Zero-length request: handshake only.
    send_req(32'h0000_0300, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("zero_len_busy", 32'(busy), 32'd0);
      chk("zero_len_cs", 32'(ctrl_cs), 32'd0);
    end

    // Reset in the middle of a burst.
    rd_mode    = 0;
    strobe_pct = 100;
    send_req(32'h0000_0500, 32'd10);
    got3 = 1'b0;
    for (int c = 0; c < 500 && !got3; c++) begin
      @(negedge clk);
      if (ctrl_cs && beats_sent >= 3) got3 = 1'b1;
    end
    if (!got3) fail_now("mid_burst_wait_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_burst");
    exp_burst.delete();
    exp_data.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("held_reset");
    #2;
    rst_n = 1'b1;
    #1;
    chk("rerelease_req_ready", 32'(req_ready), 32'(ctrl_ready));
    chk("rerelease_busy", 32'(busy), 32'd0);
    run_req(32'h0000_0040, 32'd2);

    // Randomized requests, including addresses that wrap past 2^32.
    for (int i = 0; i < 14; i++) begin
      if (i % 4 == 0) a = 32'hFFFF_FFF0 - 32'(2 * $urandom_range(0, 8));
      else a = $urandom & 32'hFFFF_FFFE;
      n          = 32'($urandom_range(0, 25));
      rd_mode    = $urandom_range(0, 1);
      strobe_pct = $urandom_range(30, 100);
      run_req(a, n);
    end

    repeat (5) @(negedge clk);
    chk("final_words_outstanding", 32'(exp_data.size()), 32'd0);
    chk("final_bursts_outstanding", 32'(exp_burst.size()), 32'd0);
    chk("final_rd_valid", 32'(rd_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hyperram_rd_streamer.md
HYPERRAM_RD_STREAMER -- requirements
Module: hyperram_rd_streamer

Interface
REQ-001 SHALL have parameters:
- FIFO_DEPTH, default 16, read-data buffer depth in 32-bit words (power of 2, >=4).
- BURST_MAX, default 8, maximum words per ctrl burst (<= FIFO_DEPTH).
- ADDR_STEP, default 2, ctrl address increment per 32-bit word.
- LATENCY, default 3'd6, value driven on ctrl_latency.
- MODE_RD, default 2'b01, ctrl_mode code for a read.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  read request offered.
- req_ready  out  1  request accepted when both high.
- req_addr  in  32  start address.
- req_num_words  in  32  words to read.
- rd_data  out  32  read word to consumer.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts.
- busy  out  1  request in progress.
- err  out  1  sticky timeout flag.
- ctrl_ready  in  1  HyperRAM interface ready.
- ctrl_cs  out  1  burst select.
- ctrl_mode  out  2  transaction mode.
- ctrl_num_words  out  32  burst length.
- ctrl_latency  out  3  latency code.
- ctrl_addr_in  out  32  burst address.
- ctrl_rd_data_out  in  32  read word from interface.
- ctrl_rd_data_valid  in  1  read word strobe.

Function
REQ-003 SHALL implement FSM states IDLE, CREDIT, ISSUE and GAP.
REQ-004 IDLE: req_ready = ctrl_ready. On handshake, latch addr and remaining=req_num_words. If req_num_words==0, stay in IDLE and issue no burst; otherwise go to CREDIT.
REQ-005 CREDIT: blen = min(remaining, BURST_MAX). Go to ISSUE when FIFO free slots >= blen and ctrl_ready=1.
REQ-006 ISSUE: ctrl_cs=1, ctrl_mode=MODE_RD, ctrl_num_words=blen, ctrl_addr_in=current addr, all held stable for the whole burst. Count ctrl_rd_data_valid strobes. On the blen-th strobe: ctrl_cs=0 next cycle, addr += blen*ADDR_STEP (32-bit wrap), remaining -= blen, go to GAP.
REQ-007 GAP: hold ctrl_cs low for exactly one cycle, then go to CREDIT if remaining!=0, else IDLE.
REQ-008 SHALL push ctrl_rd_data_out into the FIFO on ctrl_rd_data_valid only while in ISSUE. Strobes in any other state SHALL be discarded.
REQ-009 FIFO SHALL be first-word-fall-through: rd_valid = not empty, with rd_data as head. Pop on rd_valid&&rd_ready. Simultaneous push and pop SHALL be legal at any fill level, including full.
REQ-010 Credit accounting (REQ-005) SHALL guarantee no overflow regardless of rd_ready backpressure.
REQ-011 busy=1 in every state except IDLE. ctrl_mode SHALL be 2'b00 and ctrl_num_words/ctrl_addr_in SHALL be 0 when ctrl_cs=0. ctrl_latency SHALL always equal LATENCY.
REQ-012 Word order at rd_data SHALL equal strobe order. No word SHALL be dropped or duplicated.

Reset
REQ-013 On rst_n low, asynchronously:
- FSM goes to IDLE; FIFO empties.
- Outputs: req_ready=0, rd_valid=0, rd_data=0, busy=0, err=0, ctrl_cs=0, ctrl_mode=0, ctrl_num_words=0, ctrl_addr_in=0.
REQ-014 Reset mid-burst SHALL abort the burst and discard all buffered data. The first cycle after rst_n rises SHALL be IDLE with req_ready=ctrl_ready.

Configuration
REQ-015 Macro HYPERRAM_RD_TIMEOUT_EN:
- Defined: a 16-bit watchdog counts ISSUE cycles without a strobe and resets on each strobe. On reaching 16'hFFFF: drop ctrl_cs, set err sticky until reset, discard remaining, go to GAP then IDLE. Words already buffered SHALL remain readable.
- Undefined: no watchdog logic; err tied 0.

Verification
REQ-016 Request addr=0x100, num_words=5, rd_ready=1, interface returns 5 strobes -> one burst with ctrl_num_words=5, addr 0x100. rd_data out in order. busy falls 1 cycle after GAP.
REQ-017 num_words=20, BURST_MAX=8 -> bursts of 8, 8, 4 at addrs A, A+16, A+32. Exactly 1 GAP cycle between bursts.
REQ-018 num_words=40, rd_ready=0 until FIFO holds 16 -> CREDIT stalls with ctrl_cs=0 and no overflow. Releasing rd_ready drains all 40 in order.
REQ-019 num_words=0 -> req_ready handshake occurs, ctrl_cs never asserts, busy stays 0.
REQ-020 rst_n low during burst word 3 -> all outputs at reset values. Next request (addr 0x40, 2 words) completes normally.
REQ-021 With HYPERRAM_RD_TIMEOUT_EN, interface sends 2 of 8 strobes then stops -> err=1 after 65535 cycles. 2 words readable, FSM returns to IDLE.
